pipeline_hazard_ctrl: RTL and testbench

Hazard and stall sequencer for the 5-stage pipeline. It drives the write-enable and flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It detects load-use hazards, flushes on taken branches resolved in EX, and freezes the pipeline while data memory is not ready. A 3-state FSM handles multi-cycle memory waits with a timeout, and saturating counters record performance statistics.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 38 +++
 rtl/sat_counter.sv | 17 +
 rtl/pipeline_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall sequencer.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned REG_W   = 5;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // Hazard kinds; a larger encoding wins when several are present.
  typedef enum logic [1:0] {
    HZ_NONE     = 2'd0,
    HZ_LOAD_USE = 2'd1,
    HZ_BRANCH   = 2'd2,
    HZ_MEMSTALL = 2'd3
  } hazard_e;

  // Highest-priority hazard: a memory freeze overrides everything else.
  localparam hazard_e HZ_TOP_PRIORITY = HZ_MEMSTALL;

  // Pick the winning hazard: memstall > branch > load_use.
  function automatic hazard_e hazard_sel(input logic memstall,
                                         input logic branch,
                                         input logic load_use);
    hazard_e hz;
    hz = HZ_NONE;
    if (memstall)      hz = HZ_TOP_PRIORITY;
    else if (branch)   hz = HZ_BRANCH;
    else if (load_use) hz = HZ_LOAD_USE;
    return hz;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline statistics.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                     count <= '0;
    else if (inc && (count != '1)) count <= count + W'(1);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline: load-use stalls,
// taken-branch flushes and data-memory freezes with a wait timeout.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [4:0]       i_IFID_Rs,
  input  logic [4:0]       i_IFID_Rt,
  input  logic             i_IFID_UsesRt,
  input  logic             i_IDEX_MemRead,
  input  logic [4:0]       i_IDEX_Rt,
  input  logic             i_EX_BranchTaken,
  input  logic             i_dmem_req,
  input  logic             i_dmem_ready,
  output logic             o_PCWrite,
  output logic             o_IFID_Write,
  output logic             o_IFID_Flush,
  output logic             o_IDEX_Flush,
  output logic             o_EXMEM_Write,
  output logic             o_MEMWB_Flush,
  output logic [1:0]       o_state,
  output logic             o_error,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic [CNT_W-1:0] o_memwait_cnt
);

  localparam int unsigned TMR_W = $clog2(MEM_TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             error_q;
  logic             load_use, memstall;
  hazard_e          hz;
  logic             inc_stall, inc_flush, inc_memwait;

  // Raw hazard conditions from the ID/EX/MEM stage fields.
  assign load_use = i_IDEX_MemRead && (i_IDEX_Rt != REG_ZERO) &&
                    ((i_IFID_Rs == i_IDEX_Rt) ||
                     (i_IFID_UsesRt && (i_IFID_Rt == i_IDEX_Rt)));
  assign memstall = i_dmem_req && !i_dmem_ready;

  // State, wait timer and sticky error registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_RUN;
      timer_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      error_q <= error_q || (state_d == ST_ERROR);
    end
  end

  // Next state: enter MEM_WAIT on a stall, time out into ERROR.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ST_RUN: begin
        if (memstall) begin
          state_d = ST_MEM_WAIT;
          timer_d = TMR_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (memstall) begin
          timer_d = timer_q + TMR_W'(1);
          if (timer_d == TMR_W'(MEM_TIMEOUT)) state_d = ST_ERROR;
        end else begin
          state_d = ST_RUN;
          timer_d = '0;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_RUN;
        timer_d = '0;
      end
    endcase
  end

  // Pipeline controls and statistic strobes; all quiet while in reset.
  always_comb begin
    hz            = HZ_NONE;
    o_PCWrite     = 1'b0;
    o_IFID_Write  = 1'b0;
    o_IFID_Flush  = 1'b0;
    o_IDEX_Flush  = 1'b0;
    o_EXMEM_Write = 1'b0;
    o_MEMWB_Flush = 1'b0;
    inc_stall     = 1'b0;
    inc_flush     = 1'b0;
    inc_memwait   = 1'b0;
    if (i_rstn) begin
      case (state_q)
        ST_RUN:      hz = hazard_sel(memstall, i_EX_BranchTaken, load_use);
        // Held branch/load-use hazards are re-evaluated on release.
        ST_MEM_WAIT: hz = hazard_sel(memstall, i_EX_BranchTaken, load_use);
        ST_ERROR:    hz = HZ_TOP_PRIORITY;
        default:     hz = HZ_NONE;
      endcase
      o_PCWrite     = 1'b1;
      o_IFID_Write  = 1'b1;
      o_EXMEM_Write = 1'b1;
      case (hz)
        HZ_MEMSTALL: begin
          o_PCWrite     = 1'b0;
          o_IFID_Write  = 1'b0;
          o_EXMEM_Write = 1'b0;
          o_MEMWB_Flush = 1'b1;
          inc_memwait   = (state_q != ST_ERROR);
        end
        HZ_BRANCH: begin
          o_IFID_Flush = 1'b1;
          o_IDEX_Flush = 1'b1;
          inc_flush    = 1'b1;
        end
        HZ_LOAD_USE: begin
          o_PCWrite    = 1'b0;
          o_IFID_Write = 1'b0;
          o_IDEX_Flush = 1'b1;
          inc_stall    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_state = state_q;
  assign o_error = error_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (i_clk),
    .rstn  (i_rstn),
    .inc   (inc_stall),
    .count (o_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (i_clk),
    .rstn  (i_rstn),
    .inc   (inc_flush),
    .count (o_flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_memwait_cnt (
    .clk   (i_clk),
    .rstn  (i_rstn),
    .inc   (inc_memwait),
    .count (o_memwait_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table plus multi-cycle sequences.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned NVEC  = 10;

  // ctrl = {PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Write, MEMWB_Flush}
  localparam logic [5:0] C_RUN    = 6'b110010;
  localparam logic [5:0] C_LDUSE  = 6'b000110;
  localparam logic [5:0] C_BRANCH = 6'b111110;
  localparam logic [5:0] C_FREEZE = 6'b000001;
  localparam logic [5:0] C_RESET  = 6'b000000;

  logic             i_clk = 1'b0;
  logic             i_rstn;
  logic [4:0]       i_IFID_Rs, i_IFID_Rt, i_IDEX_Rt;
  logic             i_IFID_UsesRt, i_IDEX_MemRead, i_EX_BranchTaken;
  logic             i_dmem_req, i_dmem_ready;
  logic             o_PCWrite, o_IFID_Write, o_IFID_Flush, o_IDEX_Flush;
  logic             o_EXMEM_Write, o_MEMWB_Flush, o_error;
  logic [1:0]       o_state;
  logic [CNT_W-1:0] o_stall_cnt, o_flush_cnt, o_memwait_cnt;
  logic [5:0]       ctrl;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       memread;
    logic [4:0] idex_rt;
    logic       br;
    logic       req;
    logic       rdy;
    logic [5:0] exp_ctrl;
  } vec_t;

  vec_t vecs [NVEC];

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .i_clk            (i_clk),
    .i_rstn           (i_rstn),
    .i_IFID_Rs        (i_IFID_Rs),
    .i_IFID_Rt        (i_IFID_Rt),
    .i_IFID_UsesRt    (i_IFID_UsesRt),
    .i_IDEX_MemRead   (i_IDEX_MemRead),
    .i_IDEX_Rt        (i_IDEX_Rt),
    .i_EX_BranchTaken (i_EX_BranchTaken),
    .i_dmem_req       (i_dmem_req),
    .i_dmem_ready     (i_dmem_ready),
    .o_PCWrite        (o_PCWrite),
    .o_IFID_Write     (o_IFID_Write),
    .o_IFID_Flush     (o_IFID_Flush),
    .o_IDEX_Flush     (o_IDEX_Flush),
    .o_EXMEM_Write    (o_EXMEM_Write),
    .o_MEMWB_Flush    (o_MEMWB_Flush),
    .o_state          (o_state),
    .o_error          (o_error),
    .o_stall_cnt      (o_stall_cnt),
    .o_flush_cnt      (o_flush_cnt),
    .o_memwait_cnt    (o_memwait_cnt)
  );

  assign ctrl = {o_PCWrite, o_IFID_Write, o_IFID_Flush, o_IDEX_Flush,
                 o_EXMEM_Write, o_MEMWB_Flush};

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    i_IFID_Rs        = v.rs;
    i_IFID_Rt        = v.rt;
    i_IFID_UsesRt    = v.uses_rt;
    i_IDEX_MemRead   = v.memread;
    i_IDEX_Rt        = v.idex_rt;
    i_EX_BranchTaken = v.br;
    i_dmem_req       = v.req;
    i_dmem_ready     = v.rdy;
  endtask

  task automatic idle();
    vec_t v;
    v = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_RUN};
    drive(v);
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    vec_t v;
    //          rs     rt     use   mrd   idexrt br    req   rdy   expected
    vecs[0] = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, C_RUN};
    vecs[1] = '{5'd8,  5'd1,  1'b0, 1'b1, 5'd8,  1'b0, 1'b0, 1'b0, C_LDUSE};
    vecs[2] = '{5'd3,  5'd8,  1'b1, 1'b1, 5'd8,  1'b0, 1'b0, 1'b0, C_LDUSE};
    vecs[3] = '{5'd3,  5'd8,  1'b0, 1'b1, 5'd8,  1'b0, 1'b0, 1'b0, C_RUN};
    vecs[4] = '{5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, C_RUN};
    vecs[5] = '{5'd8,  5'd8,  1'b1, 1'b0, 5'd8,  1'b0, 1'b0, 1'b0, C_RUN};
    vecs[6] = '{5'd2,  5'd4,  1'b1, 1'b0, 5'd9,  1'b1, 1'b0, 1'b0, C_BRANCH};
    vecs[7] = '{5'd8,  5'd1,  1'b0, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0, C_BRANCH};
    vecs[8] = '{5'd8,  5'd1,  1'b0, 1'b0, 5'd8,  1'b0, 1'b1, 1'b1, C_RUN};
    vecs[9] = '{5'd5,  5'd6,  1'b1, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0, C_RUN};

    // Reset with hazards present on the inputs: everything quiet.
    i_rstn = 1'b0;
    v = '{5'd8, 5'd1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, C_RESET};
    drive(v);
    #12;
    chk("reset_ctrl", 32'(ctrl), 32'(C_RESET));
    chk("reset_state", 32'(o_state), 32'd0);
    chk("reset_error", 32'(o_error), 32'd0);
    chk("reset_cnts", {20'd0, o_stall_cnt, o_flush_cnt, o_memwait_cnt}, 32'd0);
    @(negedge i_clk);
    idle();
    i_rstn = 1'b1;
    cyc();

    // Single-cycle vectors applied from RUN.
    for (int i = 0; i < int'(NVEC); i++) begin
      drive(vecs[i]);
      @(negedge i_clk);
      chk($sformatf("vec%0d_ctrl", i), 32'(ctrl), 32'(vecs[i].exp_ctrl));
      chk($sformatf("vec%0d_state", i), 32'(o_state), 32'd0);
      cyc();
    end
    chk("table_stall_cnt", 32'(o_stall_cnt), 32'd2);
    chk("table_flush_cnt", 32'(o_flush_cnt), 32'd2);
    chk("table_memwait_cnt", 32'(o_memwait_cnt), 32'd0);

    // Memory wait for 3 cycles with branch and load-use held, then release.
    v = '{5'd8, 5'd1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, C_FREEZE};
    drive(v);
    for (int k = 1; k <= 3; k++) begin
      @(negedge i_clk);
      chk($sformatf("wait%0d_ctrl", k), 32'(ctrl), 32'(C_FREEZE));
      chk($sformatf("wait%0d_state", k), 32'(o_state), (k == 1) ? 32'd0 : 32'd1);
      cyc();
    end
    chk("wait_memwait_cnt", 32'(o_memwait_cnt), 32'd3);
    chk("wait_stall_cnt", 32'(o_stall_cnt), 32'd2);
    chk("wait_flush_cnt", 32'(o_flush_cnt), 32'd2);
    i_dmem_ready = 1'b1;
    @(negedge i_clk);
    chk("release_ctrl", 32'(ctrl), 32'(C_BRANCH));
    chk("release_state_pre", 32'(o_state), 32'd1);
    cyc();
    chk("release_state_post", 32'(o_state), 32'd0);
    chk("release_flush_cnt", 32'(o_flush_cnt), 32'd3);
    chk("release_stall_cnt", 32'(o_stall_cnt), 32'd2);
    chk("release_memwait_cnt", 32'(o_memwait_cnt), 32'd3);

    // Request dropped while waiting counts as ready.
    idle();
    i_dmem_req = 1'b1;
    @(negedge i_clk);
    chk("drop_freeze_ctrl", 32'(ctrl), 32'(C_FREEZE));
    cyc();
    chk("drop_state_wait", 32'(o_state), 32'd1);
    i_dmem_req = 1'b0;
    @(negedge i_clk);
    chk("drop_release_ctrl", 32'(ctrl), 32'(C_RUN));
    cyc();
    chk("drop_state_run", 32'(o_state), 32'd0);
    chk("drop_memwait_cnt", 32'(o_memwait_cnt), 32'd4);

    // Asynchronous reset in the middle of a memory wait.
    i_dmem_req = 1'b1;
    cyc();
    chk("midwait_state", 32'(o_state), 32'd1);
    #2;
    i_rstn = 1'b0;
    #1;
    chk("midwait_rst_state", 32'(o_state), 32'd0);
    chk("midwait_rst_cnts", {20'd0, o_stall_cnt, o_flush_cnt, o_memwait_cnt}, 32'd0);
    chk("midwait_rst_ctrl", 32'(ctrl), 32'(C_RESET));
    @(negedge i_clk);
    idle();
    i_rstn = 1'b1;
    cyc();

    // Timeout: 16 stalled cycles lead to ERROR, which is sticky.
    i_dmem_req = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge i_clk);
      if (ctrl !== C_FREEZE) chk($sformatf("to%0d_ctrl", k), 32'(ctrl), 32'(C_FREEZE));
      cyc();
      if (k == 15) begin
        chk("to15_state", 32'(o_state), 32'd1);
        chk("to15_error", 32'(o_error), 32'd0);
      end
    end
    chk("to16_state", 32'(o_state), 32'd2);
    chk("to16_error", 32'(o_error), 32'd1);
    chk("to_memwait_sat", 32'(o_memwait_cnt), 32'd15);
    i_dmem_ready = 1'b1;
    i_dmem_req   = 1'b0;
    i_EX_BranchTaken = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      chk($sformatf("err%0d_ctrl", k), 32'(ctrl), 32'(C_FREEZE));
      chk($sformatf("err%0d_state", k), 32'(o_state), 32'd2);
      cyc();
    end
    chk("err_sticky", 32'(o_error), 32'd1);
    chk("err_flush_cnt", 32'(o_flush_cnt), 32'd0);
    #2;
    i_rstn = 1'b0;
    #1;
    chk("err_rst_state", 32'(o_state), 32'd0);
    chk("err_rst_error", 32'(o_error), 32'd0);
    chk("err_rst_cnts", {20'd0, o_stall_cnt, o_flush_cnt, o_memwait_cnt}, 32'd0);
    chk("err_rst_ctrl", 32'(ctrl), 32'(C_RESET));
    @(negedge i_clk);
    idle();
    i_rstn = 1'b1;
    cyc();

    // Saturation: 20 load-use cycles on a 4-bit counter stop at 15.
    drive(vecs[1]);
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      if (i == 0 || i == 19) chk($sformatf("sat%0d_ctrl", i), 32'(ctrl), 32'(C_LDUSE));
      cyc();
      if (i == 13) chk("sat_stall_14", 32'(o_stall_cnt), 32'd14);
    end
    chk("sat_stall_15", 32'(o_stall_cnt), 32'd15);
    idle();
    @(negedge i_clk);
    chk("sat_after_ctrl", 32'(ctrl), 32'(C_RUN));
    cyc();
    chk("sat_hold", 32'(o_stall_cnt), 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
